// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed N-digit 7-segment scan controller with ghost gap and frame-synchronous double-buffered writes.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GAP    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  wr_valid,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic                  wr_ready,
    output logic [3:0]            char,
    output logic                  blank,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame
);
    localparam int CMAX = DIV > GAP ? DIV : GAP;
    localparam int CW   = $clog2(CMAX);
    localparam int IW   = $clog2(DIGITS);

    typedef enum logic [1:0] {S_OFF, S_ON, S_GAP} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   active_q, active_d;
    logic [4*DIGITS-1:0]   pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic                  wr_ready_q;
    logic [DIGITS-1:0]     an_n_q;
    logic [3:0]            char_q;
    logic                  blank_q;
    logic                  frame_q;
    logic                  adv, boundary, commit, take, lz, lit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        adv      = 1'b0;
        boundary = 1'b0;
        if (!en) begin
            state_d = S_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == S_OFF) begin
            state_d = S_ON;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == S_ON) begin
            if (cnt_q == CW'(DIV - 1)) begin
                cnt_d    = '0;
                boundary = idx_q == IW'(DIGITS - 1);
                adv      = GAP == 0;
                state_d  = GAP == 0 ? S_ON : S_GAP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == CW'(GAP - 1)) begin
                cnt_d   = '0;
                adv     = 1'b1;
                state_d = S_ON;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (adv) idx_d = idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
        // pend_full blocks new transfers, so commit and take never coincide
        commit      = pend_full_q && (boundary || state_q == S_OFF);
        take        = wr_valid && !pend_full_q;
        active_d    = commit ? pend_q : active_q;
        pend_d      = take ? wr_data : pend_q;
        pend_full_d = commit ? 1'b0 : take ? 1'b1 : pend_full_q;
`ifdef SEG_LZB_EN
        lz = idx_d != '0 && (active_d >> (4 * idx_d)) == '0;
`else
        lz = 1'b0;
`endif
        lit = state_d == S_ON && !lz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_OFF;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            wr_ready_q  <= 1'b1;
            an_n_q      <= '1;
            char_q      <= '0;
            blank_q     <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            wr_ready_q  <= !pend_full_d;
            an_n_q      <= lit ? ~(DIGITS'(1) << idx_d) : '1;
            char_q      <= active_d[4*idx_d +: 4];
            blank_q     <= !lit;
            frame_q     <= boundary;
        end
    end

    assign wr_ready = wr_ready_q;
    assign an_n     = an_n_q;
    assign char     = char_q;
    assign blank    = blank_q;
    assign frame    = frame_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl; dut uses DIV=4 GAP=1, dut2 uses DIV=2 GAP=0, both DIGITS=4.
module tb_seg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, wr_valid;
    logic [15:0] wr_data;
    logic        wr_ready, blank, frame, wr_ready2, blank2, frame2;
    logic [3:0]  chr, an_n, chr2, an_n2;
    int          total = 0;
    int          bad = 0;

    seg_scan_ctrl #(.DIGITS(4), .DIV(4), .GAP(1)) dut (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .char(chr), .blank(blank), .an_n(an_n), .frame(frame)
    );

    seg_scan_ctrl #(.DIGITS(4), .DIV(2), .GAP(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready2), .char(chr2), .blank(blank2), .an_n(an_n2), .frame(frame2)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        en = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic load_and_start(input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data = d;
        step();
        wr_valid = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_dut();
        total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL reset_an_n got=%b exp=1111", an_n); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%b exp=1", blank); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        total++; if (chr !== 4'h0) begin bad++; $display("FAIL reset_char got=%h exp=0", chr); end
        total++; if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", frame); end
    endtask

    task automatic test_scan();
        logic [15:0] w;
        logic [3:0]  e_an;
        int d, p;
        w = 16'h1234;
        reset_dut();
        wr_valid = 1'b1;
        wr_data = w;
        step();
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL off_write_busy got=%b exp=0", wr_ready); end
        wr_valid = 1'b0;
        step();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL off_commit_ready got=%b exp=1", wr_ready); end
        en = 1'b1;
        step();
        for (int t = 0; t < 40; t++) begin
            d = (t / 5) % 4;
            p = t % 5;
            e_an = p < 4 ? ~(4'b0001 << d) : 4'b1111;
            total++; if (an_n !== e_an) begin bad++; $display("FAIL scan_an_n t=%0d got=%b exp=%b", t, an_n, e_an); end
            total++; if (blank !== (p == 4)) begin bad++; $display("FAIL scan_blank t=%0d got=%b exp=%b", t, blank, p == 4); end
            if (p < 4) begin
                total++; if (chr !== w[4*d +: 4]) begin bad++; $display("FAIL scan_char t=%0d got=%h exp=%h", t, chr, w[4*d +: 4]); end
            end
            total++; if (frame !== (t % 20 == 19)) begin bad++; $display("FAIL scan_frame t=%0d got=%b exp=%b", t, frame, t % 20 == 19); end
            step();
        end
    endtask

    task automatic test_mid_write();
        logic [15:0] w;
        int d, p;
        reset_dut();
        load_and_start(16'h1234);
        for (int t = 0; t < 40; t++) begin
            d = (t / 5) % 4;
            p = t % 5;
            w = t < 20 ? 16'h1234 : 16'hABCD;
            total++; if (wr_ready !== (t < 3 || t >= 19)) begin bad++; $display("FAIL mid_wr_ready t=%0d got=%b exp=%b", t, wr_ready, t < 3 || t >= 19); end
            if (p < 4) begin
                total++; if (chr !== w[4*d +: 4]) begin bad++; $display("FAIL mid_char t=%0d got=%h exp=%h", t, chr, w[4*d +: 4]); end
            end
            if (t == 2) begin
                wr_valid = 1'b1;
                wr_data = 16'hABCD;
            end
            // a held request with different data must not be captured while busy
            if (t == 3) wr_data = 16'hFFFF;
            if (t == 6) wr_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_no_gap();
        logic [15:0] w;
        logic [3:0]  e_an;
        int d;
        w = 16'h1234;
        reset_dut();
        load_and_start(w);
        for (int t = 0; t < 24; t++) begin
            d = (t / 2) % 4;
            e_an = ~(4'b0001 << d);
            total++; if (an_n2 !== e_an) begin bad++; $display("FAIL nogap_an_n t=%0d got=%b exp=%b", t, an_n2, e_an); end
            total++; if (chr2 !== w[4*d +: 4]) begin bad++; $display("FAIL nogap_char t=%0d got=%h exp=%h", t, chr2, w[4*d +: 4]); end
            total++; if (frame2 !== (t > 0 && t % 8 == 0)) begin bad++; $display("FAIL nogap_frame t=%0d got=%b exp=%b", t, frame2, t > 0 && t % 8 == 0); end
            step();
        end
    endtask

    task automatic test_en_drop();
        logic [3:0] e_an;
        reset_dut();
        load_and_start(16'h1234);
        for (int t = 0; t < 11; t++) step();
        total++; if (an_n !== 4'b1011) begin bad++; $display("FAIL drop_pre_an_n got=%b exp=1011", an_n); end
        en = 1'b0;
        step();
        total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL drop_an_n got=%b exp=1111", an_n); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL drop_blank got=%b exp=1", blank); end
        step();
        total++; if (an_n !== 4'b1111) begin bad++; $display("FAIL drop_hold_an_n got=%b exp=1111", an_n); end
        en = 1'b1;
        step();
        for (int t = 0; t < 6; t++) begin
            e_an = t < 4 ? 4'b1110 : t == 4 ? 4'b1111 : 4'b1101;
            total++; if (an_n !== e_an) begin bad++; $display("FAIL restart_an_n t=%0d got=%b exp=%b", t, an_n, e_an); end
            if (t < 4) begin
                total++; if (chr !== 4'h4) begin bad++; $display("FAIL restart_char t=%0d got=%h exp=4", t, chr); end
            end
            step();
        end
    endtask

    task automatic test_lzb();
        logic [15:0] w;
        logic [3:0]  e_an;
        logic        on;
        int d, p;
        w = 16'h0050;
        reset_dut();
        load_and_start(w);
        for (int t = 0; t < 20; t++) begin
            d = (t / 5) % 4;
            p = t % 5;
`ifdef SEG_LZB_EN
            on = p < 4 && d <= 1;
`else
            on = p < 4;
`endif
            e_an = on ? ~(4'b0001 << d) : 4'b1111;
            total++; if (an_n !== e_an) begin bad++; $display("FAIL lzb_an_n t=%0d got=%b exp=%b", t, an_n, e_an); end
            total++; if (blank !== !on) begin bad++; $display("FAIL lzb_blank t=%0d got=%b exp=%b", t, blank, !on); end
            if (on) begin
                total++; if (chr !== w[4*d +: 4]) begin bad++; $display("FAIL lzb_char t=%0d got=%h exp=%h", t, chr, w[4*d +: 4]); end
            end
            total++; if (frame !== (t == 19)) begin bad++; $display("FAIL lzb_frame t=%0d got=%b exp=%b", t, frame, t == 19); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mid_write();
        test_no_gap();
        test_en_drop();
        test_lzb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
